// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with a sign fix-up folded into the final step.
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] X,
    input  logic [XLEN-1:0] Y,
    input  logic [3:0]      OP,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] OUTPUT,
    output logic            illegal
);
    localparam int CW = $clog2(XLEN);
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_MULH = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd10;
    localparam logic [3:0] OP_REM  = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd14;
    localparam logic [3:0] OP_REMU = 4'd15;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_reg;
    logic [CW-1:0]   count_reg;
    logic [3:0]      op_reg;
    logic [XLEN-1:0] hi_reg, lo_reg, b_reg, x_reg;
    logic            neg_reg, y_zero_reg;
    logic            req_ready_reg, resp_valid_reg, illegal_reg;
    logic [XLEN-1:0] output_reg;

    // Issue-side decode: signed ops work on magnitudes, sign applied at the end.
    logic            in_signed, in_mul, in_neg;
    logic [XLEN-1:0] x_mag, y_mag;

    assign in_signed = (OP == OP_MULH) || (OP == OP_DIV) || (OP == OP_REM);
    assign in_mul    = (OP == OP_MUL) || (OP == OP_MULH);
    assign x_mag     = (in_signed && X[XLEN-1]) ? -X : X;
    assign y_mag     = (in_signed && Y[XLEN-1]) ? -Y : Y;

    always_comb begin
        in_neg = 1'b0;
        case (OP)
            OP_MULH, OP_DIV: in_neg = X[XLEN-1] ^ Y[XLEN-1];
            OP_REM:          in_neg = X[XLEN-1];
            default:         in_neg = 1'b0;
        endcase
    end

    // One radix-2 step. Multiply: {hi,lo} shifts right with the partial sum
    // in hi. Divide: hi is the partial remainder, lo shifts quotient bits in.
    logic            mul_op, illegal_op, ge;
    logic [XLEN:0]   sum, shifted;
    logic [XLEN-1:0] diff, hi_next, lo_next;

    assign mul_op     = (op_reg == OP_MUL) || (op_reg == OP_MULH);
    assign illegal_op = !(op_reg inside {OP_MUL, OP_MULH, OP_DIV, OP_REM, OP_DIVU, OP_REMU});

    assign sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    assign shifted = {hi_reg, lo_reg[XLEN-1]};
    assign ge      = shifted >= {1'b0, b_reg};
    assign diff    = shifted[XLEN-1:0] - b_reg;
    assign hi_next = mul_op ? sum[XLEN:1] : (ge ? diff : shifted[XLEN-1:0]);
    assign lo_next = mul_op ? {sum[0], lo_reg[XLEN-1:1]} : {lo_reg[XLEN-2:0], ge};

    logic [XLEN-1:0] result_next;

    always_comb begin
        result_next = '0;
        case (op_reg)
            OP_MUL:  result_next = lo_next;
            // High half of the negated 2*XLEN product: ~hi plus the carry out of -lo.
            OP_MULH: result_next = neg_reg ? (~hi_next + {{(XLEN-1){1'b0}}, (lo_next == '0)})
                                           : hi_next;
            OP_DIV, OP_DIVU: result_next = y_zero_reg ? '1 : (neg_reg ? -lo_next : lo_next);
            OP_REM, OP_REMU: result_next = y_zero_reg ? x_reg : (neg_reg ? -hi_next : hi_next);
            default: result_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            op_reg         <= '0;
            hi_reg         <= '0;
            lo_reg         <= '0;
            b_reg          <= '0;
            x_reg          <= '0;
            neg_reg        <= 1'b0;
            y_zero_reg     <= 1'b0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            output_reg     <= '0;
            illegal_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        op_reg        <= OP;
                        x_reg         <= X;
                        y_zero_reg    <= (Y == '0);
                        neg_reg       <= in_neg;
                        hi_reg        <= '0;
                        lo_reg        <= in_mul ? y_mag : x_mag;
                        b_reg         <= in_mul ? x_mag : y_mag;
                        count_reg     <= '0;
                        req_ready_reg <= 1'b0;
                        state_reg     <= BUSY;
                    end
                end
                BUSY: begin
                    hi_reg    <= hi_next;
                    lo_reg    <= lo_next;
                    count_reg <= count_reg + CW'(1);
                    if (count_reg == CW'(XLEN - 1)) begin
                        output_reg     <= result_next;
                        illegal_reg    <= illegal_op;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign OUTPUT     = output_reg;
    assign illegal    = illegal_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RISC-V M cases plus random ops, checked
// against a plain-arithmetic reference model.
module tb_muldiv_unit;
    localparam int XLEN = 64;
    localparam logic [63:0] MIN_INT = 64'h8000000000000000;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [XLEN-1:0] X = '0;
    logic [XLEN-1:0] Y = '0;
    logic [3:0]      OP = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [XLEN-1:0] OUTPUT;
    logic            illegal;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .X(X), .Y(Y), .OP(OP),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .OUTPUT(OUTPUT), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: {illegal, result} from RISC-V M rules using native arithmetic.
    function automatic logic [64:0] model(input logic [3:0] op, input logic [63:0] x,
                                          input logic [63:0] y);
        logic signed [127:0] sx128, sy128, prod;
        logic signed [63:0]  sx, sy;
        sx = x;
        sy = y;
        sx128 = {{64{x[63]}}, x};
        sy128 = {{64{y[63]}}, y};
        case (op)
            4'd8:  return {1'b0, 64'(x * y)};
            4'd9: begin
                prod = sx128 * sy128;
                return {1'b0, prod[127:64]};
            end
            4'd10: begin
                if (y == 0) return {1'b0, 64'hFFFFFFFFFFFFFFFF};
                if (x == MIN_INT && y == 64'hFFFFFFFFFFFFFFFF) return {1'b0, x};
                return {1'b0, 64'(sx / sy)};
            end
            4'd11: begin
                if (y == 0) return {1'b0, x};
                if (x == MIN_INT && y == 64'hFFFFFFFFFFFFFFFF) return 65'd0;
                return {1'b0, 64'(sx % sy)};
            end
            4'd14: return (y == 0) ? {1'b0, 64'hFFFFFFFFFFFFFFFF} : {1'b0, x / y};
            4'd15: return (y == 0) ? {1'b0, x} : {1'b0, x % y};
            default: return {1'b1, 64'd0};
        endcase
    endfunction

    // Issue one op, measure latency, optionally stall the response and poke
    // req_valid during BUSY, then complete the handshake.
    task automatic run_op(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y,
                          input int hold, input bit poke_busy);
        logic [64:0] exp;
        int          lat, t;
        logic [63:0] held;
        exp = model(op, x, y);
        @(negedge clk);
        req_valid = 1'b1; OP = op; X = x; Y = y;
        t = 0;
        while (!req_ready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) check("accept_timeout", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        if (poke_busy) begin
            OP = 4'd8; X = $urandom; Y = $urandom;
        end else req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (poke_busy && lat == 3) check("busy_req_ready", 64'(req_ready), 64'd0);
        end while (!resp_valid && lat < 200);
        req_valid = 1'b0;
        check("latency", 64'(lat), 64'(XLEN + 1));
        check("result", OUTPUT, exp[63:0]);
        check("illegal", 64'(illegal), 64'(exp[64]));
        held = OUTPUT;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_output", OUTPUT, held);
            check("hold_req_ready", 64'(req_ready), 64'd0);
            check("hold_resp_valid", 64'(resp_valid), 64'd1);
        end
        $display("op=%0d x=%h y=%h out=%h ill=%0b lat=%0d exp=%h",
                 op, x, y, OUTPUT, illegal, lat, exp[63:0]);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("post_req_ready", 64'(req_ready), 64'd1);
        check("post_resp_valid", 64'(resp_valid), 64'd0);
    endtask

    task automatic reset_mid_busy();
        int seen;
        @(negedge clk);
        req_valid = 1'b1; OP = 4'd10; X = 64'd100; Y = 64'd7;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        seen = 0;
        repeat (XLEN + 10) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("rst_no_response", 64'(seen), 64'd0);
        $display("reset mid-busy: responses seen after abort=%0d", seen);
    endtask

    logic [3:0] op_tab [8] = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd14, 4'd15, 4'd3, 4'd12};

    initial begin
        logic [63:0] rx, ry;
        logic [3:0]  rop;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_resp_valid", 64'(resp_valid), 64'd0);
        check("reset_output", OUTPUT, 64'd0);
        check("reset_illegal", 64'(illegal), 64'd0);

        run_op(4'd8, 64'd6, 64'd5, 0, 1'b0);
        run_op(4'd9, MIN_INT, 64'd4, 0, 1'b0);
        run_op(4'd10, 64'd66, 64'd11, 0, 1'b0);
        run_op(4'd11, 64'd62, 64'd3, 0, 1'b0);
        run_op(4'd10, -64'sd7, 64'd2, 0, 1'b0);
        run_op(4'd11, -64'sd7, 64'd2, 0, 1'b0);
        run_op(4'd10, 64'd9, 64'd0, 0, 1'b0);
        run_op(4'd14, 64'd9, 64'd0, 0, 1'b0);
        run_op(4'd11, 64'd9, 64'd0, 0, 1'b0);
        run_op(4'd15, 64'd9, 64'd0, 0, 1'b0);
        run_op(4'd11, -64'sd9, 64'd0, 0, 1'b0);
        run_op(4'd10, MIN_INT, 64'hFFFFFFFFFFFFFFFF, 0, 1'b0);
        run_op(4'd11, MIN_INT, 64'hFFFFFFFFFFFFFFFF, 0, 1'b0);
        run_op(4'd9, -64'sd3, -64'sd5, 0, 1'b0);
        run_op(4'd9, 64'hFFFFFFFFFFFFFFFF, 64'd1, 0, 1'b0);
        run_op(4'd8, 64'h123456789ABCDEF0, 64'hFEDCBA9876543210, 5, 1'b1);
        reset_mid_busy();
        run_op(4'd3, 64'd12, 64'd4, 2, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rop = op_tab[$urandom_range(0, 7)];
            rx  = {$urandom, $urandom};
            ry  = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: ry = 64'd0;
                1: begin rx = MIN_INT; ry = 64'hFFFFFFFFFFFFFFFF; end
                2: ry = 64'($urandom_range(1, 1000));
                3: ry = -64'($urandom_range(1, 1000));
                default: ;
            endcase
            run_op(rop, rx, ry, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
